// File: rtl/mannix_regs_pkg.sv
// Shared constants for the mannix control/status register bank:
// register offsets, STATUS/IRQ bit positions and packed-field LSBs.
package mannix_regs_pkg;

  localparam logic [7:0] OFF_CTRL       = 8'h00;
  localparam logic [7:0] OFF_STATUS     = 8'h04;
  localparam logic [7:0] OFF_IRQ_EN     = 8'h08;
  localparam logic [7:0] OFF_FC_ADDRX   = 8'h10;
  localparam logic [7:0] OFF_FC_ADDRY   = 8'h14;
  localparam logic [7:0] OFF_FC_ADDRB   = 8'h18;
  localparam logic [7:0] OFF_FC_XM      = 8'h1C;
  localparam logic [7:0] OFF_FC_YM      = 8'h20;
  localparam logic [7:0] OFF_FC_YN      = 8'h24;
  localparam logic [7:0] OFF_CNN_BN     = 8'h28;
  localparam logic [7:0] OFF_FC_ADDRZ   = 8'h2C;
  localparam logic [7:0] OFF_CNN_ADDR_X = 8'h30;
  localparam logic [7:0] OFF_CNN_ADDR_Y = 8'h34;
  localparam logic [7:0] OFF_CNN_ADDR_Z = 8'h38;
  localparam logic [7:0] OFF_CNN_DIMS   = 8'h3C;
  localparam logic [7:0] OFF_POOL_RD    = 8'h40;
  localparam logic [7:0] OFF_POOL_WR    = 8'h44;
  localparam logic [7:0] OFF_POOL_DIMS  = 8'h48;

  localparam int ST_FC_BUSY   = 0;
  localparam int ST_CNN_BUSY  = 1;
  localparam int ST_POOL_BUSY = 2;
  localparam int ST_FC_DONE   = 8;
  localparam int ST_CNN_DONE  = 9;
  localparam int ST_POOL_DONE = 10;
  localparam int ST_ERR       = 16;

  localparam int IRQ_FC   = 0;
  localparam int IRQ_CNN  = 1;
  localparam int IRQ_POOL = 2;
  localparam int IRQ_ERR  = 3;

  localparam int CNN_XM_LSB   = 0;
  localparam int CNN_XN_LSB   = 8;
  localparam int CNN_YM_LSB   = 16;
  localparam int CNN_YN_LSB   = 20;
  localparam int POOL_RDM_LSB = 0;
  localparam int POOL_RDN_LSB = 4;
  localparam int POOL_M_LSB   = 8;
  localparam int POOL_N_LSB   = 12;

endpackage

// File: rtl/mannix_busy_edge.sv
// Registers an engine busy level and flags its 1->0 transition.
module mannix_busy_edge (
  input  logic clk,
  input  logic rst_n,
  input  logic busy,
  output logic fall
);

  logic busy_r;

  // Previous-cycle busy level; restarts at 0 so a busy held through reset is not a completion
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      busy_r <= 1'b0;
    end else begin
      busy_r <= busy;
    end
  end

  assign fall = busy_r & ~busy;

endmodule

// File: rtl/mannix_ctrl_regs.sv
// Software register bank in front of mannix: configuration storage, fc_go
// generation, busy write protection, sticky completions and level irq.
module mannix_ctrl_regs #(
  parameter int ADDR_WIDTH         = 19,
  parameter int X_LOG2_ROWS_NUM    = 7,
  parameter int X_LOG2_COLS_NUM    = 7,
  parameter int Y_LOG2_ROWS_NUM    = 2,
  parameter int Y_LOG2_COLS_NUM    = 2,
  parameter int DATA_LOG2_ROWS_NUM = 2,
  parameter int DATA_LOG2_COLS_NUM = 2,
  parameter int OUT_LOG2_ROWS_NUM  = 1,
  parameter int OUT_LOG2_COLS_NUM  = 1
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic                          sw_wr_en,
  input  logic                          sw_rd_en,
  input  logic [7:0]                    sw_addr,
  input  logic [31:0]                   sw_wdata,
  output logic [31:0]                   sw_rdata,
  output logic                          sw_rvalid,
  output logic                          irq,
  output logic [31:0]                   fc_addrx,
  output logic [31:0]                   fc_addry,
  output logic [31:0]                   fc_addrb,
  output logic [31:0]                   fc_xm,
  output logic [31:0]                   fc_ym,
  output logic [31:0]                   fc_yn,
  output logic [31:0]                   cnn_bn,
  output logic                          fc_go,
  input  logic [31:0]                   fc_addrz,
  input  logic                          fc_done,
  input  logic                          fc_sw_busy_ind,
  output logic [ADDR_WIDTH-1:0]         sw_cnn_addr_x,
  output logic [ADDR_WIDTH-1:0]         sw_cnn_addr_y,
  output logic [ADDR_WIDTH-1:0]         sw_cnn_addr_z,
  output logic [X_LOG2_ROWS_NUM:0]      sw_cnn_x_m,
  output logic [X_LOG2_COLS_NUM:0]      sw_cnn_x_n,
  output logic [Y_LOG2_ROWS_NUM:0]      sw_cnn_y_m,
  output logic [Y_LOG2_COLS_NUM:0]      sw_cnn_y_n,
  input  logic                          cnn_sw_busy_ind,
  output logic [ADDR_WIDTH-1:0]         sw_pool_rd_addr,
  output logic [ADDR_WIDTH-1:0]         sw_pool_wr_addr,
  output logic [DATA_LOG2_ROWS_NUM-1:0] sw_pool_rd_m,
  output logic [DATA_LOG2_COLS_NUM-1:0] sw_pool_rd_n,
  output logic [OUT_LOG2_ROWS_NUM-1:0]  sw_pool_m,
  output logic [OUT_LOG2_COLS_NUM-1:0]  sw_pool_n,
  input  logic                          pool_sw_busy_ind
);

  import mannix_regs_pkg::*;

  localparam int XMW = X_LOG2_ROWS_NUM + 1;
  localparam int XNW = X_LOG2_COLS_NUM + 1;
  localparam int YMW = Y_LOG2_ROWS_NUM + 1;
  localparam int YNW = Y_LOG2_COLS_NUM + 1;

  logic [7:0]  word_s;
  logic        fc_grp_s, cnn_grp_s, pool_grp_s;
  logic        blocked_s, cfg_we_s, go_req_s, go_ok_s, err_set_s, w1c_s;
  logic        cnn_fall_s, pool_fall_s;
  logic [3:0]  irq_src_s;
  logic [31:0] rdata_s;
  logic [3:0]  irq_en_r;
  logic        fc_done_st_r, cnn_done_r, pool_done_r, err_r, go_pending_r;
  logic        unused_s;

  assign unused_s = ^sw_addr[1:0];

  mannix_busy_edge u_cnn_edge (
    .clk   (clk),
    .rst_n (rst_n),
    .busy  (cnn_sw_busy_ind),
    .fall  (cnn_fall_s)
  );

  mannix_busy_edge u_pool_edge (
    .clk   (clk),
    .rst_n (rst_n),
    .busy  (pool_sw_busy_ind),
    .fall  (pool_fall_s)
  );

  // Write decode: config groups are locked while their engine is busy
  always_comb begin
    word_s     = {sw_addr[7:2], 2'b00};
    fc_grp_s   = (word_s >= OFF_FC_ADDRX)   && (word_s <= OFF_CNN_BN);
    cnn_grp_s  = (word_s >= OFF_CNN_ADDR_X) && (word_s <= OFF_CNN_DIMS);
    pool_grp_s = (word_s >= OFF_POOL_RD)    && (word_s <= OFF_POOL_DIMS);
    blocked_s  = sw_wr_en && ((fc_grp_s && fc_sw_busy_ind) ||
                              (cnn_grp_s && cnn_sw_busy_ind) ||
                              (pool_grp_s && pool_sw_busy_ind));
    cfg_we_s   = sw_wr_en && !blocked_s;
    go_req_s   = sw_wr_en && (word_s == OFF_CTRL) && sw_wdata[0];
    go_ok_s    = go_req_s && !fc_sw_busy_ind && !go_pending_r;
    err_set_s  = blocked_s || (go_req_s && !go_ok_s);
    w1c_s      = sw_wr_en && (word_s == OFF_STATUS);
  end

  // Configuration registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fc_addrx <= 32'd0; fc_addry <= 32'd0; fc_addrb <= 32'd0;
      fc_xm    <= 32'd0; fc_ym    <= 32'd0; fc_yn    <= 32'd0;
      cnn_bn   <= 32'd0;
      sw_cnn_addr_x   <= '0; sw_cnn_addr_y   <= '0; sw_cnn_addr_z <= '0;
      sw_cnn_x_m      <= '0; sw_cnn_x_n      <= '0;
      sw_cnn_y_m      <= '0; sw_cnn_y_n      <= '0;
      sw_pool_rd_addr <= '0; sw_pool_wr_addr <= '0;
      sw_pool_rd_m    <= '0; sw_pool_rd_n    <= '0;
      sw_pool_m       <= '0; sw_pool_n       <= '0;
      irq_en_r        <= 4'd0;
    end else if (cfg_we_s) begin
      case (word_s)
        OFF_IRQ_EN:     irq_en_r <= sw_wdata[3:0];
        OFF_FC_ADDRX:   fc_addrx <= sw_wdata;
        OFF_FC_ADDRY:   fc_addry <= sw_wdata;
        OFF_FC_ADDRB:   fc_addrb <= sw_wdata;
        OFF_FC_XM:      fc_xm    <= sw_wdata;
        OFF_FC_YM:      fc_ym    <= sw_wdata;
        OFF_FC_YN:      fc_yn    <= sw_wdata;
        OFF_CNN_BN:     cnn_bn   <= sw_wdata;
        OFF_CNN_ADDR_X: sw_cnn_addr_x <= sw_wdata[ADDR_WIDTH-1:0];
        OFF_CNN_ADDR_Y: sw_cnn_addr_y <= sw_wdata[ADDR_WIDTH-1:0];
        OFF_CNN_ADDR_Z: sw_cnn_addr_z <= sw_wdata[ADDR_WIDTH-1:0];
        OFF_CNN_DIMS: begin
          sw_cnn_x_m <= sw_wdata[CNN_XM_LSB +: XMW];
          sw_cnn_x_n <= sw_wdata[CNN_XN_LSB +: XNW];
          sw_cnn_y_m <= sw_wdata[CNN_YM_LSB +: YMW];
          sw_cnn_y_n <= sw_wdata[CNN_YN_LSB +: YNW];
        end
        OFF_POOL_RD:    sw_pool_rd_addr <= sw_wdata[ADDR_WIDTH-1:0];
        OFF_POOL_WR:    sw_pool_wr_addr <= sw_wdata[ADDR_WIDTH-1:0];
        OFF_POOL_DIMS: begin
          sw_pool_rd_m <= sw_wdata[POOL_RDM_LSB +: DATA_LOG2_ROWS_NUM];
          sw_pool_rd_n <= sw_wdata[POOL_RDN_LSB +: DATA_LOG2_COLS_NUM];
          sw_pool_m    <= sw_wdata[POOL_M_LSB +: OUT_LOG2_ROWS_NUM];
          sw_pool_n    <= sw_wdata[POOL_N_LSB +: OUT_LOG2_COLS_NUM];
        end
        default: begin end
      endcase
    end
  end

  always_comb begin
    irq_src_s           = 4'd0;
    irq_src_s[IRQ_FC]   = fc_done_st_r;
    irq_src_s[IRQ_CNN]  = cnn_done_r;
    irq_src_s[IRQ_POOL] = pool_done_r;
    irq_src_s[IRQ_ERR]  = err_r;
  end

  // Go pulse, re-arm tracking, sticky status (set beats W1C) and interrupt
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fc_go        <= 1'b0;
      go_pending_r <= 1'b0;
      fc_done_st_r <= 1'b0;
      cnn_done_r   <= 1'b0;
      pool_done_r  <= 1'b0;
      err_r        <= 1'b0;
      irq          <= 1'b0;
    end else begin
      fc_go <= go_ok_s;
      if (go_ok_s) begin
        go_pending_r <= 1'b1;
      end else if (fc_sw_busy_ind || fc_done) begin
        go_pending_r <= 1'b0;
      end
      fc_done_st_r <= fc_done     | (fc_done_st_r & ~(w1c_s & sw_wdata[ST_FC_DONE]));
      cnn_done_r   <= cnn_fall_s  | (cnn_done_r   & ~(w1c_s & sw_wdata[ST_CNN_DONE]));
      pool_done_r  <= pool_fall_s | (pool_done_r  & ~(w1c_s & sw_wdata[ST_POOL_DONE]));
      err_r        <= err_set_s   | (err_r        & ~(w1c_s & sw_wdata[ST_ERR]));
      irq          <= |(irq_en_r & irq_src_s);
    end
  end

  // Read mux; unused high bits and unmapped offsets return 0
  always_comb begin
    rdata_s = 32'd0;
    case (word_s)
      OFF_STATUS: begin
        rdata_s[ST_FC_BUSY]   = fc_sw_busy_ind;
        rdata_s[ST_CNN_BUSY]  = cnn_sw_busy_ind;
        rdata_s[ST_POOL_BUSY] = pool_sw_busy_ind;
        rdata_s[ST_FC_DONE]   = fc_done_st_r;
        rdata_s[ST_CNN_DONE]  = cnn_done_r;
        rdata_s[ST_POOL_DONE] = pool_done_r;
        rdata_s[ST_ERR]       = err_r;
      end
      OFF_IRQ_EN:     rdata_s[3:0] = irq_en_r;
      OFF_FC_ADDRX:   rdata_s = fc_addrx;
      OFF_FC_ADDRY:   rdata_s = fc_addry;
      OFF_FC_ADDRB:   rdata_s = fc_addrb;
      OFF_FC_XM:      rdata_s = fc_xm;
      OFF_FC_YM:      rdata_s = fc_ym;
      OFF_FC_YN:      rdata_s = fc_yn;
      OFF_CNN_BN:     rdata_s = cnn_bn;
      OFF_FC_ADDRZ:   rdata_s = fc_addrz;
      OFF_CNN_ADDR_X: rdata_s[ADDR_WIDTH-1:0] = sw_cnn_addr_x;
      OFF_CNN_ADDR_Y: rdata_s[ADDR_WIDTH-1:0] = sw_cnn_addr_y;
      OFF_CNN_ADDR_Z: rdata_s[ADDR_WIDTH-1:0] = sw_cnn_addr_z;
      OFF_CNN_DIMS: begin
        rdata_s[CNN_XM_LSB +: XMW] = sw_cnn_x_m;
        rdata_s[CNN_XN_LSB +: XNW] = sw_cnn_x_n;
        rdata_s[CNN_YM_LSB +: YMW] = sw_cnn_y_m;
        rdata_s[CNN_YN_LSB +: YNW] = sw_cnn_y_n;
      end
      OFF_POOL_RD:    rdata_s[ADDR_WIDTH-1:0] = sw_pool_rd_addr;
      OFF_POOL_WR:    rdata_s[ADDR_WIDTH-1:0] = sw_pool_wr_addr;
      OFF_POOL_DIMS: begin
        rdata_s[POOL_RDM_LSB +: DATA_LOG2_ROWS_NUM] = sw_pool_rd_m;
        rdata_s[POOL_RDN_LSB +: DATA_LOG2_COLS_NUM] = sw_pool_rd_n;
        rdata_s[POOL_M_LSB +: OUT_LOG2_ROWS_NUM]    = sw_pool_m;
        rdata_s[POOL_N_LSB +: OUT_LOG2_COLS_NUM]    = sw_pool_n;
      end
      default: rdata_s = 32'd0;
    endcase
  end

  // Registered read port
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sw_rdata  <= 32'd0;
      sw_rvalid <= 1'b0;
    end else begin
      sw_rvalid <= sw_rd_en;
      sw_rdata  <= sw_rd_en ? rdata_s : 32'd0;
    end
  end

endmodule

// File: tb/tb_mannix_ctrl_regs.sv
// Directed bench for mannix_ctrl_regs: reads are scoreboarded through a queue
// popped by a monitor on sw_rvalid; level outputs are compared directly.
module tb_mannix_ctrl_regs;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        sw_wr_en, sw_rd_en;
  logic [7:0]  sw_addr;
  logic [31:0] sw_wdata, sw_rdata;
  logic        sw_rvalid, irq, fc_go;
  logic [31:0] fc_addrx, fc_addry, fc_addrb, fc_xm, fc_ym, fc_yn, cnn_bn;
  logic [31:0] fc_addrz;
  logic        fc_done, fc_sw_busy_ind, cnn_sw_busy_ind, pool_sw_busy_ind;
  logic [18:0] sw_cnn_addr_x, sw_cnn_addr_y, sw_cnn_addr_z;
  logic [7:0]  sw_cnn_x_m, sw_cnn_x_n;
  logic [2:0]  sw_cnn_y_m, sw_cnn_y_n;
  logic [18:0] sw_pool_rd_addr, sw_pool_wr_addr;
  logic [1:0]  sw_pool_rd_m, sw_pool_rd_n;
  logic [0:0]  sw_pool_m, sw_pool_n;

  int errors = 0;
  int checks = 0;
  string       name_q[$];
  logic [31:0] data_q[$];

  always #5 clk = ~clk;

  mannix_ctrl_regs dut (
    .clk(clk), .rst_n(rst_n),
    .sw_wr_en(sw_wr_en), .sw_rd_en(sw_rd_en), .sw_addr(sw_addr),
    .sw_wdata(sw_wdata), .sw_rdata(sw_rdata), .sw_rvalid(sw_rvalid), .irq(irq),
    .fc_addrx(fc_addrx), .fc_addry(fc_addry), .fc_addrb(fc_addrb),
    .fc_xm(fc_xm), .fc_ym(fc_ym), .fc_yn(fc_yn), .cnn_bn(cnn_bn),
    .fc_go(fc_go), .fc_addrz(fc_addrz), .fc_done(fc_done),
    .fc_sw_busy_ind(fc_sw_busy_ind),
    .sw_cnn_addr_x(sw_cnn_addr_x), .sw_cnn_addr_y(sw_cnn_addr_y),
    .sw_cnn_addr_z(sw_cnn_addr_z),
    .sw_cnn_x_m(sw_cnn_x_m), .sw_cnn_x_n(sw_cnn_x_n),
    .sw_cnn_y_m(sw_cnn_y_m), .sw_cnn_y_n(sw_cnn_y_n),
    .cnn_sw_busy_ind(cnn_sw_busy_ind),
    .sw_pool_rd_addr(sw_pool_rd_addr), .sw_pool_wr_addr(sw_pool_wr_addr),
    .sw_pool_rd_m(sw_pool_rd_m), .sw_pool_rd_n(sw_pool_rd_n),
    .sw_pool_m(sw_pool_m), .sw_pool_n(sw_pool_n),
    .pool_sw_busy_ind(pool_sw_busy_ind)
  );

  // Monitor: every returned read is matched against the oldest expectation
  always @(negedge clk) begin
    if (rst_n && sw_rvalid) begin
      checks++;
      if (data_q.size() == 0) begin
        errors++;
        $display("FAIL unexpected_read: got 0x%08h, nothing expected", sw_rdata);
      end else begin
        string       n;
        logic [31:0] e;
        n = name_q.pop_front();
        e = data_q.pop_front();
        if (sw_rdata !== e) begin
          errors++;
          $display("FAIL %s: read 0x%08h expected 0x%08h", n, sw_rdata, e);
        end
      end
    end
  end

  task automatic chk(input string n, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", n, act, exp);
    end
  endtask

  task automatic wr(input logic [7:0] a, input logic [31:0] d);
    @(posedge clk); #1;
    sw_wr_en = 1'b1; sw_addr = a; sw_wdata = d;
    @(posedge clk); #1;
    sw_wr_en = 1'b0;
  endtask

  task automatic rd(input string n, input logic [7:0] a, input logic [31:0] e);
    @(posedge clk); #1;
    sw_rd_en = 1'b1; sw_addr = a;
    name_q.push_back(n); data_q.push_back(e);
    @(posedge clk); #1;
    sw_rd_en = 1'b0;
  endtask

  task automatic step();
    @(posedge clk); #1;
  endtask

  initial begin
    rst_n = 1'b0; sw_wr_en = 1'b0; sw_rd_en = 1'b0; sw_addr = 8'h00;
    sw_wdata = 32'd0; fc_addrz = 32'd0; fc_done = 1'b0;
    fc_sw_busy_ind = 1'b0; cnn_sw_busy_ind = 1'b0; pool_sw_busy_ind = 1'b0;
    #12;
    chk("rst_fc_go", {31'd0, fc_go}, 32'd0);
    chk("rst_irq", {31'd0, irq}, 32'd0);
    chk("rst_rvalid", {31'd0, sw_rvalid}, 32'd0);
    @(posedge clk); #1 rst_n = 1'b1;

    // Every offset reads 0 after reset, including unmapped ones
    for (int a = 0; a <= 8'h4C; a += 4) rd("rst_read", a[7:0], 32'd0);
    rd("rst_unmapped_80", 8'h80, 32'd0);
    fc_addrz = 32'hDEAD_BEEF;
    rd("fc_addrz_view", 8'h2C, 32'hDEAD_BEEF);

    // Config write, then fc_go one cycle after the CTRL write for one cycle
    wr(8'h1C, 32'h40);
    chk("fc_xm", fc_xm, 32'h40);
    wr(8'h00, 32'h1);
    chk("fc_go_high", {31'd0, fc_go}, 32'd1);
    step();
    chk("fc_go_low", {31'd0, fc_go}, 32'd0);

    // Second go before busy/done is rejected and sets err
    wr(8'h00, 32'h1);
    chk("go_rejected", {31'd0, fc_go}, 32'd0);
    rd("status_err", 8'h04, 32'h0001_0000);
    wr(8'h04, 32'h0001_0000);
    rd("status_err_clr", 8'h04, 32'd0);
    step(); fc_done = 1'b1; step(); fc_done = 1'b0;
    rd("status_fc_done", 8'h04, 32'h0000_0100);
    wr(8'h00, 32'h1);
    chk("go_rearmed", {31'd0, fc_go}, 32'd1);
    fc_sw_busy_ind = 1'b1;
    rd("status_fc_busy", 8'h04, 32'h0000_0101);
    wr(8'h10, 32'h1234);
    chk("fc_addrx_locked", fc_addrx, 32'd0);
    rd("status_fc_lock_err", 8'h04, 32'h0001_0101);
    fc_sw_busy_ind = 1'b0;
    wr(8'h04, 32'h0001_0100);
    rd("status_clr_all", 8'h04, 32'd0);

    // IRQ_EN is 4 bits wide
    wr(8'h08, 32'hFFFF_FFFF);
    rd("irq_en_width", 8'h08, 32'h0000_000F);
    wr(8'h08, 32'h8);

    // CNN write while busy is dropped; err raises irq one cycle later
    cnn_sw_busy_ind = 1'b1;
    step();
    wr(8'h30, 32'h123);
    chk("cnn_addr_x_locked", {13'd0, sw_cnn_addr_x}, 32'd0);
    chk("irq_not_yet", {31'd0, irq}, 32'd0);
    step();
    chk("irq_err", {31'd0, irq}, 32'd1);
    rd("status_cnn_err", 8'h04, 32'h0001_0002);
    cnn_sw_busy_ind = 1'b0;
    step();
    rd("status_cnn_done", 8'h04, 32'h0001_0200);
    wr(8'h08, 32'h0);
    wr(8'h04, 32'h0001_0200);
    chk("irq_cleared", {31'd0, irq}, 32'd0);
    rd("status_cnn_clr", 8'h04, 32'd0);

    // POOL fall sets sticky; a coincident W1C loses to the set
    pool_sw_busy_ind = 1'b1; step(); step();
    pool_sw_busy_ind = 1'b0; step();
    rd("status_pool_done", 8'h04, 32'h0000_0400);
    pool_sw_busy_ind = 1'b1; step(); step();
    pool_sw_busy_ind = 1'b0;
    sw_wr_en = 1'b1; sw_addr = 8'h04; sw_wdata = 32'h400;
    step();
    sw_wr_en = 1'b0;
    rd("status_set_wins", 8'h04, 32'h0000_0400);
    wr(8'h04, 32'h400);
    rd("status_pool_clr", 8'h04, 32'd0);

    // Packed-field and address truncation
    wr(8'h3C, 32'hFFFF_FFFF);
    chk("cnn_x_m", {24'd0, sw_cnn_x_m}, 32'hFF);
    chk("cnn_x_n", {24'd0, sw_cnn_x_n}, 32'hFF);
    chk("cnn_y_m", {29'd0, sw_cnn_y_m}, 32'h7);
    chk("cnn_y_n", {29'd0, sw_cnn_y_n}, 32'h7);
    rd("cnn_dims", 8'h3C, 32'h0077_FFFF);
    wr(8'h48, 32'hFFFF_FFFF);
    chk("pool_rd_m", {30'd0, sw_pool_rd_m}, 32'h3);
    chk("pool_n", {31'd0, sw_pool_n}, 32'h1);
    rd("pool_dims", 8'h48, 32'h0000_1133);
    wr(8'h38, 32'hFFFF_FFFF);
    chk("cnn_addr_z", {13'd0, sw_cnn_addr_z}, 32'h0007_FFFF);
    rd("cnn_addr_z_rd", 8'h38, 32'h0007_FFFF);
    wr(8'h80, 32'hFFFF_FFFF);
    rd("unmapped_wr", 8'h80, 32'd0);
    rd("ctrl_reads_0", 8'h00, 32'd0);

    // Simultaneous read and write of one offset returns the old value
    @(posedge clk); #1;
    sw_rd_en = 1'b1; sw_wr_en = 1'b1; sw_addr = 8'h20; sw_wdata = 32'h55;
    name_q.push_back("rd_wr_old"); data_q.push_back(32'd0);
    step();
    sw_rd_en = 1'b0; sw_wr_en = 1'b0;
    rd("rd_wr_new", 8'h20, 32'h55);

    // Asynchronous reset while fc_go is high and irq is set
    wr(8'h08, 32'h1);
    step(); fc_done = 1'b1; step(); fc_done = 1'b0; step();
    chk("irq_fc_done", {31'd0, irq}, 32'd1);
    wr(8'h00, 32'h1);
    chk("go_before_rst", {31'd0, fc_go}, 32'd1);
    #3 rst_n = 1'b0;
    #1;
    chk("arst_fc_go", {31'd0, fc_go}, 32'd0);
    chk("arst_irq", {31'd0, irq}, 32'd0);
    chk("arst_fc_xm", fc_xm, 32'd0);
    chk("arst_fc_ym", fc_ym, 32'd0);
    chk("arst_cnn_x_m", {24'd0, sw_cnn_x_m}, 32'd0);
    chk("arst_cnn_addr_z", {13'd0, sw_cnn_addr_z}, 32'd0);
    chk("arst_pool_rd_m", {30'd0, sw_pool_rd_m}, 32'd0);
    @(posedge clk); #1 rst_n = 1'b1;
    rd("post_rst_status", 8'h04, 32'd0);
    rd("post_rst_irq_en", 8'h08, 32'd0);
    rd("post_rst_fc_xm", 8'h1C, 32'd0);

    repeat (4) step();
    chk("reads_drained", name_q.size(), 32'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation exceeded time budget");
    $fatal(1);
  end

endmodule
